adc_buffer_reader: RTL and testbench

//  Read-side engine for the ADC sample buffer RAM filled by the acquisition writer.
//  On a start pulse it reads LENGTH consecutive words from BASE_ADDR, wrapping modulo the RAM depth.
//  It strips each word to its 12-bit sample and streams it out on a valid/ready interface.

---
 rtl/adc_buffer_reader_if.sv | 35 +++
 rtl/adc_buffer_reader.sv | 189 ++++++++++++++++++
 tb/tb_adc_buffer_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_buffer_reader_if.sv
// adc_buffer_reader_if: bundles the RAM read port and the sample stream of the
// ADC buffer reader. The master side is the reader itself; the slave side is
// the RAM plus the downstream sample sink.
interface adc_buffer_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       out_data;
    logic              out_last;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/adc_buffer_reader.sv
// adc_buffer_reader: streams LENGTH 12-bit samples out of the ADC buffer RAM,
// starting at a base address and wrapping modulo the RAM depth. Reads are
// issued only while the skid FIFO has room for every word already in flight,
// so backpressure on the output never drops or duplicates a sample.
module adc_buffer_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              busy_o,
    output logic              done_o,
    adc_buffer_reader_if.master bus
);
    // The FIFO must absorb every outstanding read plus one word held at the
    // head and one being pushed, hence the fixed RD_LAT+2 depth.
    localparam int FIFO_D = RD_LAT + 2;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [RD_LAT-1:0] lat_valid;
    logic [RD_LAT-1:0] lat_last;
    logic [12:0]       fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  in_flight;
    logic              credit_ok;
    logic              issue;
    logic              issue_last;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [12:0]       head;
    logic              unused_upper;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Only the low 12 bits of a RAM word carry the sample.
    assign unused_upper = ^bus.rd_data[DATA_W-1:12];

    // Count reads issued to the RAM whose data has not yet reached the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + CNT_W'(lat_valid[i]);
        end
    end

    // Read issue is allowed only while FIFO occupancy plus outstanding reads
    // leave a free slot; the tap of the latency pipe is the FIFO push.
    always_comb begin
        credit_ok  = (SUM_W'(fifo_count) + SUM_W'(in_flight)) < SUM_W'(FIFO_D);
        issue      = (state == READ) && credit_ok;
        issue_last = issue && (remaining == LEN_W'(1));
        push       = lat_valid[RD_LAT-1];
        fifo_empty = (fifo_count == '0);
        pop        = !fifo_empty && bus.out_ready;
        head       = fifo_mem[rd_ptr];
    end

    // Drive the RAM port and the sample stream; data is forced to zero while
    // nothing is valid so an idle or freshly reset block shows all-zero outputs.
    always_comb begin
        bus.rd_en     = issue;
        bus.rd_addr   = cur_addr;
        bus.out_valid = !fifo_empty;
        bus.out_data  = fifo_empty ? 12'h000 : head[11:0];
        bus.out_last  = !fifo_empty && head[12];
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode. DRAIN looks ahead at the pop of the final
    // word so done_o lands in the very cycle after the last handshake.
    always_comb begin
        state_next = state;
        busy_o     = (state != IDLE);
        done_o     = (state == FIN);
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (length_i == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((in_flight == '0) &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request on an accepted start, then walk the address (wrapping
    // naturally at the RAM depth) and count down the words still to issue.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && start_i) begin
            cur_addr  <= base_addr_i;
            remaining <= length_i;
        end else if (issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Track each read and its last flag through the RAM latency.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            lat_valid <= '0;
            lat_last  <= '0;
        end else begin
            lat_valid[0] <= issue;
            lat_last[0]  <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_valid[i] <= lat_valid[i-1];
                lat_last[i]  <= lat_last[i-1];
            end
        end
    end

    // FIFO storage: the sample and its last flag, written as the RAM data lands.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {lat_last[RD_LAT-1], bus.rd_data[11:0]};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_buffer_reader.sv
// tb_adc_buffer_reader: directed tests for the ADC buffer reader with a RAM
// model and a queue-based reference of the expected address and sample stream.
`timescale 1ns/1ps
module tb_adc_buffer_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
    localparam int FIFO_D = RD_LAT + 2;
    localparam int LEN_W  = ADDR_W + 1;

    logic              clk_i = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [LEN_W-1:0]  length_i = '0;
    logic              busy_o;
    logic              done_o;

    adc_buffer_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_buffer_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .start_i(start_i),
        .base_addr_i(base_addr_i),
        .length_i(length_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: data for an address appears RD_LAT cycles after it is presented.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ram_pipe [RD_LAT];

    always @(posedge clk_i) begin
        ram_pipe[0] <= bus.rd_addr;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end

    assign bus.rd_data = ram[ram_pipe[RD_LAT-1]];

    // Reference model and bookkeeping.
    int                total = 0;
    int                bad = 0;
    int                issued = 0;
    int                popped = 0;
    int                done_cnt = 0;
    int                cyc = 0;
    logic              done_due = 1'b0;
    logic              ready_toggle = 1'b0;
    logic [ADDR_W-1:0] addr_q[$];
    logic [12:0]       exp_q[$];
    logic [12:0]       seen_q[$];
    int                seen_cyc[$];
    logic [ADDR_W-1:0] addr_seen[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] seen_at(input int i);
        if (i < seen_q.size()) return 32'(seen_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        if (i < addr_seen.size()) return 32'(addr_seen[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Compare process: every cycle out of reset, check read addresses, the
    // credit limit, the sample stream and the done pulse against the model.
    always @(negedge clk_i) begin
        if (rst_n) begin
            cyc++;
            check_output("done_pulse", 32'(done_o), 32'(done_due));
            if (done_o) done_cnt++;
            done_due = 1'b0;
            if (bus.rd_en) begin
                issued++;
                addr_seen.push_back(bus.rd_addr);
                check_range("reads_ahead", issued - popped, 1, FIFO_D);
                if (addr_q.size() == 0) begin
                    check_output("rd_en_unexpected", 32'(bus.rd_en), 32'h0);
                end else begin
                    check_output("rd_addr", 32'(bus.rd_addr), 32'(addr_q[0]));
                    void'(addr_q.pop_front());
                end
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("out_valid_unexpected", 32'(bus.out_valid), 32'h0);
                end else begin
                    check_output("out_data", 32'(bus.out_data), 32'(exp_q[0][11:0]));
                    check_output("out_last", 32'(bus.out_last), 32'(exp_q[0][12]));
                    if (bus.out_ready) begin
                        seen_q.push_back({bus.out_last, bus.out_data});
                        seen_cyc.push_back(cyc);
                        popped++;
                        if (exp_q[0][12]) done_due = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        if (ready_toggle) bus.out_ready = ~bus.out_ready;
        else bus.out_ready = 1'b1;
    endtask

    // Load the model with the expected readout and pulse start while idle.
    task automatic apply_stimulus(input logic [ADDR_W-1:0] base, input int len);
        logic [ADDR_W-1:0] a;
        seen_q.delete();
        seen_cyc.delete();
        addr_seen.delete();
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), ram[a][11:0]});
        end
        base_addr_i = base;
        length_i    = LEN_W'(len);
        start_i     = 1'b1;
        step();
        start_i = 1'b0;
        if (len == 0) done_due = 1'b1;
    endtask

    // Wait (bounded) for done, optionally pulsing start in the done cycle,
    // then confirm the block has gone idle with the model fully consumed.
    task automatic wait_done(input string name, input int max_cycles, input bit poke);
        int n;
        n = 0;
        while (!done_o && n < max_cycles) begin
            step();
            n++;
        end
        check_output({name, "_done_seen"}, 32'(done_o), 32'h1);
        if (poke) begin
            start_i     = 1'b1;
            base_addr_i = 12'h555;
            length_i    = LEN_W'(5);
        end
        step();
        start_i = 1'b0;
        check_output({name, "_idle_after_done"}, 32'(busy_o), 32'h0);
        check_output({name, "_model_drained"}, 32'(exp_q.size() + addr_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int d0;
        int busy_cnt;
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = (32'($urandom) << 12) | 32'(a);
        ram[12'h020] = 32'hABCD_E5A5;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();

        // Reset state.
        check_output("reset_rd_en", 32'(bus.rd_en), 32'h0);
        check_output("reset_rd_addr", 32'(bus.rd_addr), 32'h0);
        check_output("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("reset_out_data", 32'(bus.out_data), 32'h0);
        check_output("reset_busy", 32'(busy_o), 32'h0);
        check_output("reset_done", 32'(done_o), 32'h0);
        rst_n = 1'b1;
        step();

        // Test 1: contiguous readout, ready held high.
        $display("[TB] test 1: base 0x010 len 4");
        d0 = done_cnt;
        apply_stimulus(12'h010, 4);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check_output("t1_first_valid_latency", 32'(n), 32'(RD_LAT + 1));
        wait_done("t1", 40, 1'b0);
        check_output("t1_count", 32'(seen_q.size()), 32'd4);
        check_output("t1_sample0", seen_at(0), 32'h0010);
        check_output("t1_sample3_last", seen_at(3), 32'h1013);
        check_output("t1_back_to_back", (seen_cyc.size() == 4) ? 32'(seen_cyc[3] - seen_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
        check_output("t1_done_count", 32'(done_cnt - d0), 32'd1);

        // Test 2: address wrap at the top of the RAM.
        $display("[TB] test 2: base 0xFFE len 4");
        apply_stimulus(12'hFFE, 4);
        wait_done("t2", 40, 1'b0);
        check_output("t2_addr1", addr_at(1), 32'h0FFF);
        check_output("t2_addr2", addr_at(2), 32'h0000);
        check_output("t2_sample1", seen_at(1), 32'h0FFF);
        check_output("t2_sample3_last", seen_at(3), 32'h1001);

        // Test 3: ready toggling every cycle; start pulsed in the done cycle.
        $display("[TB] test 3: base 0x100 len 8 with toggling ready");
        d0 = done_cnt;
        ready_toggle = 1'b1;
        apply_stimulus(12'h100, 8);
        wait_done("t3", 100, 1'b1);
        ready_toggle = 1'b0;
        step();
        check_output("t3_count", 32'(seen_q.size()), 32'd8);
        check_output("t3_sample4", seen_at(4), 32'h0104);
        check_output("t3_sample7_last", seen_at(7), 32'h1107);
        check_output("t3_done_count", 32'(done_cnt - d0), 32'd1);

        // Test 4: zero-length readout.
        $display("[TB] test 4: len 0");
        d0 = done_cnt;
        apply_stimulus(12'h200, 0);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy_o) busy_cnt++;
            step();
        end
        check_range("t4_busy_cycles", busy_cnt, 1, 2);
        check_output("t4_done_count", 32'(done_cnt - d0), 32'd1);
        check_output("t4_no_samples", 32'(seen_q.size()), 32'd0);

        // Test 5a: start while busy is ignored.
        $display("[TB] test 5: start while busy, then reset mid-readout");
        d0 = done_cnt;
        apply_stimulus(12'h300, 6);
        step();
        start_i     = 1'b1;
        base_addr_i = 12'h777;
        length_i    = LEN_W'(3);
        step();
        start_i = 1'b0;
        wait_done("t5", 60, 1'b0);
        check_output("t5_count", 32'(seen_q.size()), 32'd6);
        check_output("t5_sample5_last", seen_at(5), 32'h1305);
        check_output("t5_done_count", 32'(done_cnt - d0), 32'd1);

        // Test 5b: asynchronous reset in the middle of a readout.
        apply_stimulus(12'h400, 16);
        for (int i = 0; i < 6; i++) step();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_rd_en", 32'(bus.rd_en), 32'h0);
        check_output("rst_mid_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("rst_mid_out_data", 32'(bus.out_data), 32'h0);
        check_output("rst_mid_out_last", 32'(bus.out_last), 32'h0);
        check_output("rst_mid_busy", 32'(busy_o), 32'h0);
        check_output("rst_mid_rd_addr", 32'(bus.rd_addr), 32'h0);
        exp_q.delete();
        addr_q.delete();
        done_due = 1'b0;
        issued   = 0;
        popped   = 0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_output("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_output("rst_stays_idle", 32'(busy_o), 32'h0);

        // Test 6: upper bits of the RAM word are dropped.
        $display("[TB] test 6: word 0xABCDE5A5");
        apply_stimulus(12'h020, 1);
        wait_done("t6", 40, 1'b0);
        check_output("t6_sample", seen_at(0), 32'h15A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
